// File: rtl/sync_manager.sv
// Video timing analyser: measures active width/height from DE/VSYNC and emits
// optionally delayed row-start / frame-start strobes for downstream write-pointer alignment.
module sync_manager #(
  parameter int unsigned MAX_WIDTH  = 1920,
  parameter int unsigned MAX_HEIGHT = 1080,
  parameter int unsigned DELAY      = 0
) (
  input  logic                          I_rgb_clk,
  input  logic                          I_rst_n,
  input  logic                          I_rgb_de,
  input  logic                          I_rgb_hsync,
  input  logic                          I_rgb_vsync,
  output logic [$clog2(MAX_WIDTH)-1:0]  O_image_width,
  output logic [$clog2(MAX_HEIGHT)-1:0] O_image_height,
  output logic                          O_width_valid,
  output logic                          O_height_valid,
  output logic                          O_new_row,
  output logic                          O_new_frame,
  output logic                          O_image_valid
);

  localparam int unsigned W = $clog2(MAX_WIDTH);
  localparam int unsigned H = $clog2(MAX_HEIGHT);
  localparam logic [W-1:0] WSat = {W{1'b1}};
  localparam logic [H-1:0] HSat = {H{1'b1}};
  localparam logic [W:0]   WLimit = (W + 1)'(MAX_WIDTH);
  localparam logic [H:0]   HLimit = (H + 1)'(MAX_HEIGHT);

  // HSYNC carries no information this block needs.
  logic unused_hsync;
  assign unused_hsync = I_rgb_hsync;

  logic de_q, de_qq, vs_q, vs_qq;
  logic de_rise, de_fall, vs_rise;

  logic [W-1:0] wcnt_q, wcnt_d, width_q, width_d;
  logic         wvalid_q, wvalid_d;
  logic [H-1:0] lcnt_q, lcnt_d, height_q, height_d;
  logic         hvalid_q, hvalid_d;
  logic         armed_q, armed_d;
  logic         frame_pend_q, frame_pend_d;
  logic         row_stb_q, row_stb_d, frame_stb_q, frame_stb_d;
  logic         image_valid_q;

  assign de_rise = de_q & ~de_qq;
  assign de_fall = ~de_q & de_qq;
  assign vs_rise = vs_q & ~vs_qq;

  always_comb begin
    wcnt_d       = wcnt_q;
    width_d      = width_q;
    wvalid_d     = wvalid_q;
    lcnt_d       = lcnt_q;
    height_d     = height_q;
    hvalid_d     = hvalid_q;
    armed_d      = armed_q;
    frame_pend_d = frame_pend_q;

    if (de_rise) begin
      wcnt_d = W'(1);
    end else if (de_q && (wcnt_q != WSat)) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    if (de_fall) begin
      if ((wcnt_q == width_q) && (wcnt_q != '0) && ({1'b0, wcnt_q} <= WLimit)) begin
        wvalid_d = 1'b1;
      end else begin
        width_d  = wcnt_q;
        wvalid_d = 1'b0;
      end
    end

    // A line starting together with VSYNC belongs to the new frame.
    if (vs_rise) begin
      lcnt_d = de_rise ? H'(1) : '0;
    end else if (de_rise && (lcnt_q != HSat)) begin
      lcnt_d = lcnt_q + 1'b1;
    end

    if (vs_rise) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if ((lcnt_q == height_q) && (lcnt_q != '0) && ({1'b0, lcnt_q} <= HLimit)) begin
        hvalid_d = 1'b1;
      end else begin
        height_d = lcnt_q;
        hvalid_d = 1'b0;
      end
    end

    if (vs_rise) begin
      frame_pend_d = ~de_rise;
    end else if (de_rise) begin
      frame_pend_d = 1'b0;
    end

    row_stb_d   = de_rise;
    frame_stb_d = de_rise & (frame_pend_q | vs_rise);
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q          <= 1'b0;
      de_qq         <= 1'b0;
      vs_q          <= 1'b0;
      vs_qq         <= 1'b0;
      wcnt_q        <= '0;
      width_q       <= '0;
      wvalid_q      <= 1'b0;
      lcnt_q        <= '0;
      height_q      <= '0;
      hvalid_q      <= 1'b0;
      armed_q       <= 1'b0;
      frame_pend_q  <= 1'b0;
      row_stb_q     <= 1'b0;
      frame_stb_q   <= 1'b0;
      image_valid_q <= 1'b0;
    end else begin
      de_q          <= I_rgb_de;
      de_qq         <= de_q;
      vs_q          <= I_rgb_vsync;
      vs_qq         <= vs_q;
      wcnt_q        <= wcnt_d;
      width_q       <= width_d;
      wvalid_q      <= wvalid_d;
      lcnt_q        <= lcnt_d;
      height_q      <= height_d;
      hvalid_q      <= hvalid_d;
      armed_q       <= armed_d;
      frame_pend_q  <= frame_pend_d;
      row_stb_q     <= row_stb_d;
      frame_stb_q   <= frame_stb_d;
      image_valid_q <= wvalid_q & hvalid_q;
    end
  end

  generate
    if (DELAY == 0) begin : g_no_delay
      assign O_new_row   = row_stb_q;
      assign O_new_frame = frame_stb_q;
    end else begin : g_delay
      logic [DELAY-1:0] row_dly_q, frame_dly_q;

      always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
          row_dly_q   <= '0;
          frame_dly_q <= '0;
        end else begin
          row_dly_q   <= (row_dly_q << 1) | DELAY'(row_stb_q);
          frame_dly_q <= (frame_dly_q << 1) | DELAY'(frame_stb_q);
        end
      end

      assign O_new_row   = row_dly_q[DELAY-1];
      assign O_new_frame = frame_dly_q[DELAY-1];
    end
  endgenerate

  assign O_image_width  = width_q;
  assign O_image_height = height_q;
  assign O_width_valid  = wvalid_q;
  assign O_height_valid = hvalid_q;
  assign O_image_valid  = image_valid_q;

endmodule

// File: tb/tb_sync_manager.sv
// Directed bench for sync_manager: two instances (DELAY=0 and DELAY=3) share one
// generated DE/HSYNC/VSYNC stream; expectations are hand-derived per phase.
module tb_sync_manager;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;

  logic [10:0] w0, h0, w3, h3;
  logic wv0, hv0, nr0, nf0, iv0;
  logic wv3, hv3, nr3, nf3, iv3;

  always #5 clk = ~clk;

  sync_manager #(.MAX_WIDTH(1920), .MAX_HEIGHT(1080), .DELAY(0)) dut0 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_rgb_de(de), .I_rgb_hsync(hs), .I_rgb_vsync(vs),
    .O_image_width(w0), .O_image_height(h0), .O_width_valid(wv0), .O_height_valid(hv0),
    .O_new_row(nr0), .O_new_frame(nf0), .O_image_valid(iv0)
  );

  sync_manager #(.MAX_WIDTH(1920), .MAX_HEIGHT(1080), .DELAY(3)) dut3 (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_rgb_de(de), .I_rgb_hsync(hs), .I_rgb_vsync(vs),
    .O_image_width(w3), .O_image_height(h3), .O_width_valid(wv3), .O_height_valid(hv3),
    .O_new_row(nr3), .O_new_frame(nf3), .O_image_valid(iv3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event monitor: cycle index of input edges and of output strobes/changes.
  int cyc = 0, in_rise = 0, in_fall = 0, vs_rise_c = 0;
  int rows0 = 0, frames0 = 0, rows3 = 0, frames3 = 0, coinc_err = 0;
  int lat0 = -1, lat3 = -1, w_lat = -1, h_lat = -1, hv_rise = 0, iv_rise = 0;
  logic de_prev = 1'b0, vs_prev = 1'b0, hv_prev = 1'b0, iv_prev = 1'b0;
  logic [10:0] w_prev = '0, h_prev = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (de && !de_prev) in_rise = cyc;
      if (!de && de_prev) in_fall = cyc;
      if (vs && !vs_prev) vs_rise_c = cyc;
      de_prev = de;
      vs_prev = vs;
      #1;
      if (nr0) begin rows0++; lat0 = cyc - in_rise; end
      if (nf0) begin frames0++; if (!nr0) coinc_err++; end
      if (nr3) begin rows3++; lat3 = cyc - in_rise; end
      if (nf3) begin frames3++; if (!nr3) coinc_err++; end
      if (w0 != w_prev) w_lat = cyc - in_fall;
      if (h0 != h_prev) h_lat = cyc - vs_rise_c;
      if (hv0 && !hv_prev) hv_rise = cyc;
      if (iv0 && !iv_prev) iv_rise = cyc;
      w_prev = w0;
      h_prev = h0;
      hv_prev = hv0;
      iv_prev = iv0;
    end
  end

  task automatic gen_line(input int hact, input int htot, input logic vs_lvl);
    for (int x = 0; x < htot; x++) begin
      @(negedge clk);
      de = (x < hact);
      vs = vs_lvl;
      hs = (x >= htot - 2);
    end
  endtask

  // VSYNC occupies two blank lines starting two lines after the active region.
  task automatic gen_frame(input int hact, input int htot, input int vact, input int vtot);
    for (int y = 0; y < vtot; y++) begin
      gen_line((y < vact) ? hact : 0, htot, (y >= vact + 2) && (y < vact + 4));
    end
  endtask

  int r0, f0, r3, f3;

  task automatic snap();
    r0 = rows0; f0 = frames0; r3 = rows3; f3 = frames3;
  endtask

  initial begin
    // Reset held while inputs toggle randomly.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      de = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      hs = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_eq("reset_outs0", 64'({w0, h0, wv0, hv0, nr0, nf0, iv0}), 64'd0);
      check_eq("reset_outs3", 64'({w3, h3, wv3, hv3, nr3, nf3, iv3}), 64'd0);
    end
    @(negedge clk);
    de = 1'b0; vs = 1'b0; hs = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("no_early_strobe", 64'(rows0 + frames0 + rows3 + frames3), 64'd0);

    // Frame 0: width locks on second line; VSYNC only arms.
    snap();
    gen_frame(4, 16, 4, 16);
    check_eq("f0_rows", 64'(rows0 - r0), 64'd4);
    check_eq("f0_frames", 64'(frames0 - f0), 64'd0);
    check_eq("f0_width", 64'(w0), 64'd4);
    check_eq("f0_wvalid", 64'(wv0), 64'd1);
    check_eq("f0_height", 64'(h0), 64'd0);
    check_eq("f0_hvalid", 64'(hv0), 64'd0);
    check_eq("width_latency", 64'(w_lat), 64'd1);

    // Frame 1: first measured height latched, not yet valid.
    snap();
    gen_frame(4, 16, 4, 16);
    check_eq("f1_frames", 64'(frames0 - f0), 64'd1);
    check_eq("f1_height", 64'(h0), 64'd4);
    check_eq("f1_hvalid", 64'(hv0), 64'd0);
    check_eq("f1_ivalid", 64'(iv0), 64'd0);
    check_eq("height_latency", 64'(h_lat), 64'd1);

    // Frame 2: height confirmed; image_valid one cycle later.
    gen_frame(4, 16, 4, 16);
    check_eq("f2_hvalid", 64'(hv0), 64'd1);
    check_eq("f2_ivalid", 64'(iv0), 64'd1);
    check_eq("ivalid_lag", 64'(iv_rise - hv_rise), 64'd1);

    // Frame 3: steady-state strobe counts and latencies.
    snap();
    gen_frame(4, 16, 4, 16);
    check_eq("f3_rows0", 64'(rows0 - r0), 64'd4);
    check_eq("f3_frames0", 64'(frames0 - f0), 64'd1);
    check_eq("f3_rows3", 64'(rows3 - r3), 64'd4);
    check_eq("f3_frames3", 64'(frames3 - f3), 64'd1);
    check_eq("row_latency_d0", 64'(lat0), 64'd1);
    check_eq("row_latency_d3", 64'(lat3), 64'd4);
    check_eq("frame_row_coincident", 64'(coinc_err), 64'd0);
    check_eq("d3_width", 64'(w3), 64'd4);
    check_eq("d3_height", 64'(h3), 64'd4);
    check_eq("d3_ivalid", 64'(iv3), 64'd1);

    // Frame 4: width changes 4 -> 6 mid-frame.
    gen_line(4, 16, 1'b0);
    gen_line(4, 16, 1'b0);
    gen_line(6, 16, 1'b0);
    check_eq("geo_width_a", 64'(w0), 64'd6);
    check_eq("geo_wvalid_a", 64'(wv0), 64'd0);
    check_eq("geo_ivalid_a", 64'(iv0), 64'd0);
    gen_line(6, 16, 1'b0);
    check_eq("geo_width_b", 64'(w0), 64'd6);
    check_eq("geo_wvalid_b", 64'(wv0), 64'd1);
    check_eq("geo_d3_wvalid_b", 64'(wv3), 64'd1);
    for (int y = 4; y < 16; y++) gen_line(0, 16, (y == 6) || (y == 7));
    check_eq("geo_height", 64'(h0), 64'd4);
    check_eq("geo_hvalid", 64'(hv0), 64'd1);

    // Over-wide lines never validate.
    for (int k = 0; k < 3; k++) begin
      gen_line(1921, 1930, 1'b0);
      check_eq("ovf_wvalid", 64'(wv0), 64'd0);
    end
    check_eq("ovf_width", 64'(w0), 64'd1921);

    // Asynchronous reset in the middle of a line.
    @(negedge clk);
    de = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midreset_outs0", 64'({w0, h0, wv0, hv0, nr0, nf0, iv0}), 64'd0);
    check_eq("midreset_outs3", 64'({w3, h3, wv3, hv3, nr3, nf3, iv3}), 64'd0);
    @(negedge clk);
    de = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    snap();
    gen_frame(4, 16, 4, 16);
    check_eq("rA_frames", 64'(frames0 - f0), 64'd0);
    check_eq("rA_wvalid", 64'(wv0), 64'd1);
    check_eq("rA_height", 64'(h0), 64'd0);
    check_eq("rA_hvalid", 64'(hv0), 64'd0);
    gen_frame(4, 16, 4, 16);
    check_eq("rB_height", 64'(h0), 64'd4);
    check_eq("rB_hvalid", 64'(hv0), 64'd0);
    gen_frame(4, 16, 4, 16);
    check_eq("rC_hvalid", 64'(hv0), 64'd1);
    check_eq("rC_ivalid", 64'(iv0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
